// File: rtl/phase_light_ctrl.sv
// phase_light_ctrl: per-phase green/yellow/clearance sequencer returning a one-clk ready pulse to the phase decoder
module phase_light_ctrl #(
  parameter int CNT_W    = 8,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 3,
  parameter int T_PED    = 15,
  parameter int T_CLEAR  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] stare_semafor,
  output logic       ready_S,
  output logic       ready_E,
  output logic       ready_V,
  output logic       ready_N,
  output logic       ready_P,
  output logic [2:0] light_S,
  output logic [2:0] light_E,
  output logic [2:0] light_V,
  output logic [2:0] light_N,
  output logic [1:0] light_P
);
  localparam logic [CNT_W-1:0] LG = CNT_W'((T_GREEN  == 0 ? 1 : T_GREEN)  - 1);
  localparam logic [CNT_W-1:0] LY = CNT_W'((T_YELLOW == 0 ? 1 : T_YELLOW) - 1);
  localparam logic [CNT_W-1:0] LP = CNT_W'((T_PED    == 0 ? 1 : T_PED)    - 1);
  localparam logic [CNT_W-1:0] LC = CNT_W'((T_CLEAR  == 0 ? 1 : T_CLEAR)  - 1);

  typedef enum logic [2:0] {IDLE, GREEN, YELLOW, CLEAR, READY, DONE, SERVICE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_phase;
  logic             r_blink;
  logic             r_restart;

  logic             w_chg, w_mid, w_z, w_ped;
  logic [2:0]       w_l [4];
  logic [4:0]       w_r;

  assign w_chg = stare_semafor != r_phase;
  assign w_mid = r_state inside {GREEN, YELLOW, CLEAR, READY};
  assign w_z   = r_cnt == '0;
  assign w_ped = r_phase == 3'b100;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_phase   <= 3'b110;
      r_blink   <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_phase <= stare_semafor;
      if (w_chg) begin
        r_blink <= 1'b0;
        if (stare_semafor == 3'b111) begin
          r_state <= SERVICE;
          r_cnt   <= '0;
        end else if (stare_semafor[2] && stare_semafor[1:0] != 2'b00) begin
          r_state <= DONE;
          r_cnt   <= '0;
        end else if (w_mid) begin
          r_state   <= CLEAR;
          r_cnt     <= LC;
          r_restart <= 1'b1;
        end else begin
          r_state   <= GREEN;
          r_cnt     <= stare_semafor == 3'b100 ? LP : LG;
          r_restart <= 1'b0;
        end
      end else begin
        case (r_state)
          GREEN: if (tick) begin
            if (w_z) begin
              r_state <= YELLOW;
              r_cnt   <= LY;
              r_blink <= 1'b0;
            end else r_cnt <= r_cnt - 1'b1;
          end
          YELLOW: if (tick) begin
            if (w_ped) r_blink <= ~r_blink;
            if (w_z) begin
              r_state <= CLEAR;
              r_cnt   <= LC;
            end else r_cnt <= r_cnt - 1'b1;
          end
          // a restarted clearance skips READY and reopens the phase now in phase_q
          CLEAR: if (tick) begin
            if (w_z) begin
              r_state   <= r_restart ? GREEN : READY;
              r_cnt     <= r_restart ? (w_ped ? LP : LG) : '0;
              r_restart <= 1'b0;
            end else r_cnt <= r_cnt - 1'b1;
          end
          READY:   r_state <= DONE;
          SERVICE: if (tick) r_blink <= ~r_blink;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++)
      w_l[k] = r_state == SERVICE ? {1'b0, r_blink, 1'b0} :
               (r_phase == 3'(k) && r_state == GREEN)  ? 3'b001 :
               (r_phase == 3'(k) && r_state == YELLOW) ? 3'b010 : 3'b100;
    for (int k = 0; k < 5; k++)
      w_r[k] = r_state == READY && r_phase == 3'(k);
  end

  assign light_S = w_l[0];
  assign light_E = w_l[1];
  assign light_V = w_l[2];
  assign light_N = w_l[3];
  assign light_P = r_state == SERVICE ? 2'b00 :
                   (w_ped && r_state == GREEN)  ? 2'b01 :
                   (w_ped && r_state == YELLOW) ? {~r_blink, r_blink} : 2'b10;
  assign {ready_P, ready_N, ready_V, ready_E, ready_S} = w_r;
endmodule

// File: tb/tb_phase_light_ctrl.sv
// tb_phase_light_ctrl: directed checks of lamp sequencing, restart, pedestrian, service and reset behaviour
module tb_phase_light_ctrl;
  logic       clk = 0, rst = 0, tick = 0;
  logic [2:0] stare = 3'b000;
  logic       rS, rE, rV, rN, rP, qS, qE, qV, qN, qP;
  logic [2:0] lS, lE, lV, lN, mS, mE, mV, mN;
  logic [1:0] lP, mP;
  int checks = 0, errors = 0;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000;

  phase_light_ctrl #(.CNT_W(8), .T_GREEN(3), .T_YELLOW(2), .T_PED(2), .T_CLEAR(1)) u0 (
    .clk(clk), .rst(rst), .tick(tick), .stare_semafor(stare),
    .ready_S(rS), .ready_E(rE), .ready_V(rV), .ready_N(rN), .ready_P(rP),
    .light_S(lS), .light_E(lE), .light_V(lV), .light_N(lN), .light_P(lP));

  phase_light_ctrl #(.CNT_W(8), .T_GREEN(0), .T_YELLOW(2), .T_PED(2), .T_CLEAR(1)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .stare_semafor(stare),
    .ready_S(qS), .ready_E(qE), .ready_V(qV), .ready_N(qN), .ready_P(qP),
    .light_S(mS), .light_E(mE), .light_V(mV), .light_N(mN), .light_P(mP));

  always #5 clk = ~clk;

  wire [18:0] o0 = {rS, rE, rV, rN, rP, lS, lE, lV, lN, lP};
  wire [18:0] o1 = {qS, qE, qV, qN, qP, mS, mE, mV, mN, mP};

  function automatic logic [18:0] e(input logic [4:0] r, input logic [2:0] s, input logic [2:0] ea,
                                    input logic [2:0] v, input logic [2:0] n, input logic [1:0] p);
    return {r, s, ea, v, n, p};
  endfunction

  task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset", o0, e(0, R, R, R, R, 2'b10));
    rst = 1;
    cyc(1); chk("S_g1", o0, e(0, G, R, R, R, 2'b10));
    cyc(1); chk("S_g2", o0, e(0, G, R, R, R, 2'b10));
    cyc(1); chk("S_g3", o0, e(0, G, R, R, R, 2'b10));
    cyc(1); chk("S_y1", o0, e(0, Y, R, R, R, 2'b10));
    cyc(1); chk("S_y2", o0, e(0, Y, R, R, R, 2'b10));
    cyc(1); chk("S_clr", o0, e(0, R, R, R, R, 2'b10));
    cyc(1); chk("S_ready", o0, e(5'b10000, R, R, R, R, 2'b10));
    cyc(1); chk("S_done", o0, e(0, R, R, R, R, 2'b10));
    cyc(1); chk("S_done2", o0, e(0, R, R, R, R, 2'b10));

    stare = 3'b001;
    cyc(0); chk("E_g_entry", o0, e(0, R, G, R, R, 2'b10));
    cyc(0); chk("E_g_notick", o0, e(0, R, G, R, R, 2'b10));
    cyc(1); chk("E_g_tick", o0, e(0, R, G, R, R, 2'b10));
    stare = 3'b010;
    cyc(1); chk("EV_clr", o0, e(0, R, R, R, R, 2'b10));
    cyc(0); chk("EV_clr_hold", o0, e(0, R, R, R, R, 2'b10));
    cyc(1); chk("V_g1", o0, e(0, R, R, G, R, 2'b10));
    cyc(1); chk("V_g2", o0, e(0, R, R, G, R, 2'b10));
    cyc(1); chk("V_g3", o0, e(0, R, R, G, R, 2'b10));
    cyc(1); chk("V_y1", o0, e(0, R, R, Y, R, 2'b10));
    cyc(1); chk("V_y2", o0, e(0, R, R, Y, R, 2'b10));
    cyc(1); chk("V_clr", o0, e(0, R, R, R, R, 2'b10));
    cyc(1); chk("V_ready", o0, e(5'b00100, R, R, R, R, 2'b10));
    cyc(1); chk("V_done", o0, e(0, R, R, R, R, 2'b10));

    stare = 3'b100;
    cyc(0); chk("P_entry", o0, e(0, R, R, R, R, 2'b01));
    for (int i = 1; i <= 21; i++) begin
      cyc(i % 4 == 0);
      chk($sformatf("P_%0d", i), o0,
          e(i == 20 ? 5'b00001 : 5'b0, R, R, R, R,
            (i <= 7 || (i >= 12 && i <= 15)) ? 2'b01 : 2'b10));
    end

    stare = 3'b000;
    cyc(0); chk("S2_g", o0, e(0, G, R, R, R, 2'b10));
    cyc(1); chk("S2_g_tick", o0, e(0, G, R, R, R, 2'b10));
    stare = 3'b111;
    cyc(1); chk("svc_b0", o0, e(0, D, D, D, D, 2'b00));
    cyc(0); chk("svc_hold", o0, e(0, D, D, D, D, 2'b00));
    cyc(1); chk("svc_b1", o0, e(0, Y, Y, Y, Y, 2'b00));
    cyc(1); chk("svc_b0b", o0, e(0, D, D, D, D, 2'b00));
    stare = 3'b000;
    cyc(1); chk("S3_g1", o0, e(0, G, R, R, R, 2'b10));
    cyc(1); chk("S3_g2", o0, e(0, G, R, R, R, 2'b10));
    cyc(1); chk("S3_g3", o0, e(0, G, R, R, R, 2'b10));
    cyc(1); chk("S3_y1", o0, e(0, Y, R, R, R, 2'b10));

    rst = 0;
    #1;
    chk("rst_async", o0, e(0, R, R, R, R, 2'b10));
    chk("rst_async_g0", o1, e(0, R, R, R, R, 2'b10));
    cyc(1); chk("rst_hold", o0, e(0, R, R, R, R, 2'b10));
    rst = 1;
    cyc(1); chk("rel_g", o0, e(0, G, R, R, R, 2'b10));
    chk("rel_g0_g", o1, e(0, G, R, R, R, 2'b10));
    cyc(1); chk("rel_g2", o0, e(0, G, R, R, R, 2'b10));
    chk("rel_g0_y", o1, e(0, Y, R, R, R, 2'b10));

    stare = 3'b101;
    cyc(1); chk("undef_done", o0, e(0, R, R, R, R, 2'b10));
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk($sformatf("undef_hold%0d", i), o0, e(0, R, R, R, R, 2'b10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
